// File: rtl/systolic_result_collector_if.sv
// Handshake bundle between the systolic array's output row counter, the
// result collector and the downstream element consumer.
// slave  : the collector side.
// master : the environment that drives rows and consumes elements.
interface systolic_result_collector_if #(
  parameter int N_SIZE = 5,
  parameter int DATAW  = 32
);
  localparam int PTR_W = $clog2(N_SIZE);

  logic                    in_valid;
  logic                    in_ready;
  logic [PTR_W-1:0]        in_row_idx;
  logic [N_SIZE*DATAW-1:0] in_row_data;

  logic                    out_valid;
  logic                    out_ready;
  logic [DATAW-1:0]        out_data;
  logic [PTR_W-1:0]        out_row;
  logic [PTR_W-1:0]        out_col;
  logic                    out_last;

  logic                    seq_err;
  logic                    ovf_err;

  modport master (
    output in_valid, in_row_idx, in_row_data, out_ready,
    input  in_ready, out_valid, out_data, out_row, out_col, out_last,
           seq_err, ovf_err
  );

  modport slave (
    input  in_valid, in_row_idx, in_row_data, out_ready,
    output in_ready, out_valid, out_data, out_row, out_col, out_last,
           seq_err, ovf_err
  );
endinterface

// File: rtl/systolic_result_collector.sv
// Result collector: buffers the N_SIZE rows of matrix C, then streams the
// elements out in row-major order over valid/ready.
//
// state | meaning
// ------+-----------------------------------------------------------
// FILL  | accepting rows into buffer row exp_row; in_ready high
// DRAIN | presenting element (row,col); incoming rows are dropped
module systolic_result_collector #(
  parameter int N_SIZE = 5,
  parameter int DATAW  = 32
) (
  input  logic                        clk,
  input  logic                        rst_n,
  systolic_result_collector_if.slave  bus
);
  localparam int PTR_W = $clog2(N_SIZE);
  localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(N_SIZE - 1);
  localparam logic [PTR_W-1:0] ONE      = PTR_W'(1);
  localparam logic [PTR_W-1:0] ZERO     = '0;

  typedef enum logic {FILL, DRAIN} state_e;

  state_e                  state_q, state_d;
  logic [PTR_W-1:0]        exp_row_q, exp_row_d;
  logic [PTR_W-1:0]        row_q, row_d;
  logic [PTR_W-1:0]        col_q, col_d;
  logic                    in_ready_q, in_ready_d;
  logic                    out_valid_q, out_valid_d;
  logic                    out_last_q, out_last_d;
  logic                    seq_err_q, seq_err_d;
  logic                    ovf_err_q, ovf_err_d;
  logic [DATAW-1:0]        out_data_q, out_data_d;
  logic [N_SIZE*DATAW-1:0] buf_q [N_SIZE];
  logic                    buf_we;
  logic [PTR_W-1:0]        nxt_row, nxt_col;

  // Next-state, pointer and registered-output computation.
  always_comb begin
    state_d     = state_q;
    exp_row_d   = exp_row_q;
    row_d       = row_q;
    col_d       = col_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    seq_err_d   = seq_err_q;
    ovf_err_d   = ovf_err_q;
    out_data_d  = out_data_q;
    buf_we      = 1'b0;

    // Row-major successor of the current element; wrap by compare so that
    // non-power-of-2 sizes step correctly.
    if (col_q == LAST_IDX) begin
      nxt_col = ZERO;
      nxt_row = row_q + ONE;
    end else begin
      nxt_col = col_q + ONE;
      nxt_row = row_q;
    end

    case (state_q)
      FILL: begin
        if (bus.in_valid) begin
          buf_we = 1'b1;
          if (bus.in_row_idx != exp_row_q) seq_err_d = 1'b1;
          if (exp_row_q == LAST_IDX) begin
            // Row 0 is already in the buffer (N_SIZE >= 2), so the first
            // element can be registered on the same edge the last row lands.
            exp_row_d   = ZERO;
            state_d     = DRAIN;
            row_d       = ZERO;
            col_d       = ZERO;
            out_valid_d = 1'b1;
            out_last_d  = 1'b0;
            out_data_d  = buf_q[ZERO][DATAW-1:0];
          end else begin
            exp_row_d = exp_row_q + ONE;
          end
        end
      end
      DRAIN: begin
        if (bus.in_valid) ovf_err_d = 1'b1;
        if (out_valid_q && bus.out_ready) begin
          if (out_last_q) begin
            state_d     = FILL;
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
            row_d       = ZERO;
            col_d       = ZERO;
          end else begin
            row_d      = nxt_row;
            col_d      = nxt_col;
            out_data_d = buf_q[nxt_row][int'(nxt_col)*DATAW +: DATAW];
            out_last_d = (nxt_row == LAST_IDX) && (nxt_col == LAST_IDX);
          end
        end
      end
      default: state_d = FILL;
    endcase

    in_ready_d = (state_d == FILL);
  end

  // Control state, pointers and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= FILL;
      exp_row_q   <= ZERO;
      row_q       <= ZERO;
      col_q       <= ZERO;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      seq_err_q   <= 1'b0;
      ovf_err_q   <= 1'b0;
      out_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      exp_row_q   <= exp_row_d;
      row_q       <= row_d;
      col_q       <= col_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      seq_err_q   <= seq_err_d;
      ovf_err_q   <= ovf_err_d;
      out_data_q  <= out_data_d;
    end
  end

  // Matrix buffer: written by expected position, never by the incoming tag.
  always_ff @(posedge clk) begin
    if (buf_we) buf_q[exp_row_q] <= bus.in_row_data;
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_row   = row_q;
  assign bus.out_col   = col_q;
  assign bus.out_last  = out_last_q;
  assign bus.seq_err   = seq_err_q;
  assign bus.ovf_err   = ovf_err_q;
endmodule

// File: tb/tb_systolic_result_collector.sv
// Bench for the result collector: a small 3x3/8-bit instance and a default
// 5x5/32-bit instance, a matrix-level reference model, and directed scenarios.
module tb_systolic_result_collector;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] d;
    int          cy;
    bit          last;
  } cap_t;

  logic        rst_n     [2];
  logic        drv_valid [2];
  int          drv_idx   [2];
  logic [31:0] drv_elem  [2][5];
  logic        drv_ready [2];

  logic        obs_in_ready [2];
  logic        obs_valid    [2];
  logic        obs_last     [2];
  logic        obs_seq      [2];
  logic        obs_ovf      [2];
  logic [31:0] obs_data     [2];
  int          obs_row      [2];
  int          obs_col      [2];

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  cap_t cap0[$];
  cap_t cap1[$];

  // reference model state: one matrix at a time
  bit          m_live  [2];
  bit          m_drain [2];
  int          m_cnt   [2];
  int          m_k     [2];
  bit          m_seq   [2];
  bit          m_ovf   [2];
  logic [31:0] m_buf   [2][5][5];

  systolic_result_collector_if #(.N_SIZE(3), .DATAW(8))  if3 ();
  systolic_result_collector_if #(.N_SIZE(5), .DATAW(32)) if5 ();

  systolic_result_collector #(.N_SIZE(3), .DATAW(8)) dut3 (
    .clk(clk), .rst_n(rst_n[0]), .bus(if3)
  );
  systolic_result_collector #(.N_SIZE(5), .DATAW(32)) dut5 (
    .clk(clk), .rst_n(rst_n[1]), .bus(if5)
  );

  assign if3.in_valid    = drv_valid[0];
  assign if3.in_row_idx  = 2'(drv_idx[0]);
  assign if3.in_row_data = {drv_elem[0][2][7:0], drv_elem[0][1][7:0], drv_elem[0][0][7:0]};
  assign if3.out_ready   = drv_ready[0];
  assign if5.in_valid    = drv_valid[1];
  assign if5.in_row_idx  = 3'(drv_idx[1]);
  assign if5.in_row_data = {drv_elem[1][4], drv_elem[1][3], drv_elem[1][2],
                            drv_elem[1][1], drv_elem[1][0]};
  assign if5.out_ready   = drv_ready[1];

  assign obs_in_ready[0] = if3.in_ready;
  assign obs_valid[0]    = if3.out_valid;
  assign obs_last[0]     = if3.out_last;
  assign obs_seq[0]      = if3.seq_err;
  assign obs_ovf[0]      = if3.ovf_err;
  assign obs_data[0]     = {24'd0, if3.out_data};
  assign obs_row[0]      = int'(if3.out_row);
  assign obs_col[0]      = int'(if3.out_col);
  assign obs_in_ready[1] = if5.in_ready;
  assign obs_valid[1]    = if5.out_valid;
  assign obs_last[1]     = if5.out_last;
  assign obs_seq[1]      = if5.seq_err;
  assign obs_ovf[1]      = if5.ovf_err;
  assign obs_data[1]     = if5.out_data;
  assign obs_row[1]      = int'(if5.out_row);
  assign obs_col[1]      = int'(if5.out_col);

  function automatic int n_of(input int i);
    return (i == 0) ? 3 : 5;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // model update and transfer capture on each rising edge (pre-edge values)
  always @(posedge clk) begin
    cyc++;
    if (obs_valid[0] && drv_ready[0]) cap0.push_back('{obs_data[0], cyc, obs_last[0]});
    if (obs_valid[1] && drv_ready[1]) cap1.push_back('{obs_data[1], cyc, obs_last[1]});
    for (int i = 0; i < 2; i++) begin
      if (!rst_n[i]) begin
        m_live[i] = 1'b1; m_drain[i] = 1'b0; m_cnt[i] = 0; m_k[i] = 0;
        m_seq[i] = 1'b0; m_ovf[i] = 1'b0;
      end else if (m_live[i] && !m_drain[i]) begin
        if (drv_valid[i]) begin
          for (int c = 0; c < n_of(i); c++)
            m_buf[i][m_cnt[i]][c] = (i == 0) ? {24'd0, drv_elem[i][c][7:0]} : drv_elem[i][c];
          if (drv_idx[i] != m_cnt[i]) m_seq[i] = 1'b1;
          m_cnt[i]++;
          if (m_cnt[i] == n_of(i)) begin
            m_cnt[i] = 0; m_drain[i] = 1'b1; m_k[i] = 0;
          end
        end
      end else if (m_live[i]) begin
        if (drv_valid[i]) m_ovf[i] = 1'b1;
        if (drv_ready[i]) begin
          m_k[i]++;
          if (m_k[i] == n_of(i) * n_of(i)) begin
            m_drain[i] = 1'b0; m_k[i] = 0;
          end
        end
      end
    end
  end

  // compare DUT against the model every cycle, away from the rising edge
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (m_live[i]) begin
        chk($sformatf("m%0d_in_ready", i),  obs_in_ready[i], !m_drain[i]);
        chk($sformatf("m%0d_out_valid", i), obs_valid[i], m_drain[i]);
        chk($sformatf("m%0d_seq_err", i),   obs_seq[i], m_seq[i]);
        chk($sformatf("m%0d_ovf_err", i),   obs_ovf[i], m_ovf[i]);
        if (m_drain[i]) begin
          chk($sformatf("m%0d_data", i), obs_data[i], m_buf[i][m_k[i] / n_of(i)][m_k[i] % n_of(i)]);
          chk($sformatf("m%0d_row", i),  obs_row[i], m_k[i] / n_of(i));
          chk($sformatf("m%0d_col", i),  obs_col[i], m_k[i] % n_of(i));
          chk($sformatf("m%0d_last", i), obs_last[i], m_k[i] == n_of(i) * n_of(i) - 1);
        end
      end
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic present(input int i, input int idx);
    drv_valid[i] = 1'b1;
    drv_idx[i]   = idx;
    step();
    drv_valid[i] = 1'b0;
  endtask

  task automatic put3(input int idx, input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
    drv_elem[0][0] = {24'd0, a};
    drv_elem[0][1] = {24'd0, b};
    drv_elem[0][2] = {24'd0, c};
    present(0, idx);
  endtask

  task automatic wait_ready(input int i, input string nm);
    int n = 0;
    while (!obs_in_ready[i] && n < 100) begin
      step();
      n++;
    end
    chk({nm, "_drain_done"}, obs_in_ready[i], 1'b1);
  endtask

  // compare captured transfers with a literal expected list
  task automatic check_cap(input int i, input string nm, input logic [31:0] ex[25],
                           input int cnt, input int first_cy);
    cap_t got[$];
    if (i == 0) got = cap0; else got = cap1;
    chk({nm, "_count"}, got.size(), cnt);
    for (int j = 0; j < cnt && j < got.size(); j++) begin
      chk($sformatf("%s_val%0d", nm, j), got[j].d, ex[j]);
      chk($sformatf("%s_last%0d", nm, j), got[j].last, j == cnt - 1);
      if (first_cy >= 0) chk($sformatf("%s_cyc%0d", nm, j), got[j].cy, first_cy + j);
    end
  endtask

  task automatic fill19();
    put3(0, 8'h01, 8'h02, 8'h03);
    put3(1, 8'h04, 8'h05, 8'h06);
    put3(2, 8'h07, 8'h08, 8'h09);
  endtask

  initial begin
    logic [31:0] ex[25];
    int acc;
    for (int i = 0; i < 2; i++) begin
      rst_n[i] = 1'b0; drv_valid[i] = 1'b0; drv_idx[i] = 0; drv_ready[i] = 1'b0;
      for (int c = 0; c < 5; c++) drv_elem[i][c] = '0;
    end
    for (int j = 0; j < 25; j++) ex[j] = '0;
    step();
    step();
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("rst%0d_out_valid", i), obs_valid[i], 1'b0);
      chk($sformatf("rst%0d_in_ready", i),  obs_in_ready[i], 1'b1);
      chk($sformatf("rst%0d_out_last", i),  obs_last[i], 1'b0);
      chk($sformatf("rst%0d_seq_err", i),   obs_seq[i], 1'b0);
      chk($sformatf("rst%0d_ovf_err", i),   obs_ovf[i], 1'b0);
      chk($sformatf("rst%0d_out_data", i),  obs_data[i], 32'd0);
      chk($sformatf("rst%0d_out_row", i),   obs_row[i], 0);
      chk($sformatf("rst%0d_out_col", i),   obs_col[i], 0);
    end
    rst_n[0] = 1'b1;
    rst_n[1] = 1'b1;
    step();

    // 1: basic fill and drain at full rate
    for (int j = 0; j < 9; j++) ex[j] = 32'(j + 1);
    drv_ready[0] = 1'b1;
    cap0.delete();
    fill19();
    acc = cyc;
    repeat (8) step();
    chk("t1_in_ready_before_last", obs_in_ready[0], 1'b0);
    step();
    chk("t1_in_ready_after_last", obs_in_ready[0], 1'b1);
    check_cap(0, "t1", ex, 9, acc + 1);

    // 2: backpressure while element 05 is presented
    cap0.delete();
    fill19();
    repeat (4) step();
    drv_ready[0] = 1'b0;
    repeat (3) begin
      chk("t2_hold_valid", obs_valid[0], 1'b1);
      chk("t2_hold_data", obs_data[0], 32'h05);
      chk("t2_hold_row", obs_row[0], 1);
      chk("t2_hold_col", obs_col[0], 1);
      step();
    end
    drv_ready[0] = 1'b1;
    wait_ready(0, "t2");
    check_cap(0, "t2", ex, 9, -1);

    // 3: out-of-order row tags, data stored by position
    cap0.delete();
    put3(0, 8'h11, 8'h12, 8'h13);
    chk("t3_seq_clear", obs_seq[0], 1'b0);
    put3(2, 8'h21, 8'h22, 8'h23);
    chk("t3_seq_set", obs_seq[0], 1'b1);
    put3(1, 8'h31, 8'h32, 8'h33);
    acc = cyc;
    wait_ready(0, "t3");
    ex[0] = 32'h11; ex[1] = 32'h12; ex[2] = 32'h13;
    ex[3] = 32'h21; ex[4] = 32'h22; ex[5] = 32'h23;
    ex[6] = 32'h31; ex[7] = 32'h32; ex[8] = 32'h33;
    check_cap(0, "t3", ex, 9, acc + 1);
    chk("t3_seq_sticky", obs_seq[0], 1'b1);

    // 4: row presented during drain is dropped and flagged
    cap0.delete();
    fill19();
    acc = cyc;
    put3(0, 8'hFF, 8'hFF, 8'hFF);
    chk("t4_ovf_set", obs_ovf[0], 1'b1);
    wait_ready(0, "t4");
    for (int j = 0; j < 9; j++) ex[j] = 32'(j + 1);
    check_cap(0, "t4", ex, 9, acc + 1);

    // 5: reset mid-drain, then a fresh matrix
    fill19();
    repeat (4) step();
    rst_n[0] = 1'b0;
    step();
    rst_n[0] = 1'b1;
    chk("t5_out_valid", obs_valid[0], 1'b0);
    chk("t5_in_ready", obs_in_ready[0], 1'b1);
    chk("t5_seq_err", obs_seq[0], 1'b0);
    chk("t5_ovf_err", obs_ovf[0], 1'b0);
    cap0.delete();
    put3(0, 8'h41, 8'h42, 8'h43);
    put3(1, 8'h44, 8'h45, 8'h46);
    put3(2, 8'h47, 8'h48, 8'h49);
    acc = cyc;
    wait_ready(0, "t5");
    for (int j = 0; j < 9; j++) ex[j] = 32'(8'h41 + j);
    check_cap(0, "t5", ex, 9, acc + 1);

    // 6: default 5x5/32-bit instance, element value r*5+c
    drv_ready[1] = 1'b1;
    cap1.delete();
    for (int r = 0; r < 5; r++) begin
      for (int c = 0; c < 5; c++) drv_elem[1][c] = 32'(r * 5 + c);
      present(1, r);
    end
    acc = cyc;
    wait_ready(1, "t6");
    for (int j = 0; j < 25; j++) ex[j] = 32'(j);
    check_cap(1, "t6", ex, 25, acc + 1);
    chk("t6_seq_after_first", obs_seq[1], 1'b0);
    for (int r = 0; r < 5; r++) begin
      for (int c = 0; c < 5; c++) drv_elem[1][c] = 32'h1000 + 32'(r * 5 + c);
      present(1, r);
      if (r == 0) chk("t6_seq_after_wrap", obs_seq[1], 1'b0);
    end
    wait_ready(1, "t6b");
    chk("t6_seq_final", obs_seq[1], 1'b0);

    step();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
